// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB receive path.
package usb_rx_pkg;

   // Bit-unstuffer control states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RECV  = 2'd1,
      ERROR = 2'd2
   } unstuff_state_t;

   // Number of consecutive 1s after which the transmitter inserts a 0.
   localparam int STUFF_LEN_DEFAULT = 6;

endpackage : usb_rx_pkg

// File: rtl/bit_unstuffer_fsm.sv
// Control FSM for the bit unstuffer: decides per incoming bit whether it is
// passed, dropped as a stuffed 0, or flagged as a stuffing violation, and how
// the ones counter moves.
module bit_unstuffer_fsm
   import usb_rx_pkg::*;
(
   input  logic clock,
   input  logic reset_n,
   input  logic nrzi_sending,
   input  logic in_bit,
   input  logic count_full,
   output logic pass_bit,
   output logic cnt_clr,
   output logic cnt_inc,
   output logic stuff_err,
   output logic sending
);

   unstuff_state_t state, state_nxt;

   // State register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and per-bit decode. cnt_clr with cnt_inc loads 1 (first bit of
   // a packet), cnt_clr alone loads 0, cnt_inc alone increments.
   always_comb begin
      state_nxt = state;
      pass_bit  = 1'b0;
      cnt_clr   = 1'b0;
      cnt_inc   = 1'b0;
      stuff_err = 1'b0;
      sending   = 1'b0;
      unique case (state)
         IDLE: begin
            cnt_clr = 1'b1;
            if (nrzi_sending) begin
               pass_bit  = 1'b1;
               cnt_inc   = in_bit;
               sending   = 1'b1;
               state_nxt = RECV;
            end
         end
         RECV: begin
            if (!nrzi_sending) begin
               cnt_clr   = 1'b1;
               state_nxt = IDLE;
            end else if (!count_full) begin
               pass_bit = 1'b1;
               sending  = 1'b1;
               cnt_inc  = in_bit;
               cnt_clr  = ~in_bit;
            end else if (!in_bit) begin
               // Stuffed 0: swallow it and restart the run.
               sending = 1'b1;
               cnt_clr = 1'b1;
            end else begin
               // A 1 where a stuffed 0 was required.
               sending   = 1'b1;
               cnt_clr   = 1'b1;
               stuff_err = 1'b1;
               state_nxt = ERROR;
            end
         end
         ERROR: begin
            cnt_clr = 1'b1;
            if (nrzi_sending) begin
               sending = 1'b1;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: begin
            cnt_clr   = 1'b1;
            state_nxt = IDLE;
         end
      endcase
   end

endmodule : bit_unstuffer_fsm

// File: rtl/bit_unstuffer.sv
// USB receive bit unstuffer: removes the stuffed 0 after each run of
// STUFF_LEN ones and reports stuffing violations. All outputs registered,
// one cycle of latency from in_bit to out_bit.
module bit_unstuffer
   import usb_rx_pkg::*;
#(
   parameter int STUFF_LEN = STUFF_LEN_DEFAULT
) (
   input  logic clock,
   input  logic reset_n,
   input  logic in_bit,
   input  logic nrzi_sending,
   output logic out_bit,
   output logic out_valid,
   output logic unstuff_sending,
   output logic stuff_error
);

   localparam int CNT_W = $clog2(STUFF_LEN + 1);

   logic [CNT_W-1:0] ones_cnt;
   logic             count_full;
   logic             pass_bit;
   logic             cnt_clr;
   logic             cnt_inc;
   logic             stuff_err;
   logic             sending;

   assign count_full = (ones_cnt == CNT_W'(STUFF_LEN));

   bit_unstuffer_fsm u_fsm (
      .clock        (clock),
      .reset_n      (reset_n),
      .nrzi_sending (nrzi_sending),
      .in_bit       (in_bit),
      .count_full   (count_full),
      .pass_bit     (pass_bit),
      .cnt_clr      (cnt_clr),
      .cnt_inc      (cnt_inc),
      .stuff_err    (stuff_err),
      .sending      (sending)
   );

   // Consecutive-ones counter; never exceeds STUFF_LEN since a full count
   // always clears on the next bit.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ones_cnt <= '0;
      end else if (cnt_clr) begin
         ones_cnt <= cnt_inc ? CNT_W'(1) : '0;
      end else if (cnt_inc) begin
         ones_cnt <= ones_cnt + CNT_W'(1);
      end
   end

   // Output registers; out_bit only updates on passed bits and holds otherwise.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         out_bit         <= 1'b0;
         out_valid       <= 1'b0;
         unstuff_sending <= 1'b0;
         stuff_error     <= 1'b0;
      end else begin
         if (pass_bit) begin
            out_bit <= in_bit;
         end
         out_valid       <= pass_bit;
         unstuff_sending <= sending;
         stuff_error     <= stuff_err;
      end
   end

endmodule : bit_unstuffer

// File: tb/tb_bit_unstuffer.sv
// Directed testbench for bit_unstuffer: a table of per-cycle inputs and the
// outputs expected right after that cycle's clock edge, plus a hand-written
// mid-packet reset sequence.
module tb_bit_unstuffer;

   logic clock = 1'b0;
   logic reset_n;
   logic in_bit;
   logic nrzi_sending;
   logic out_bit;
   logic out_valid;
   logic unstuff_sending;
   logic stuff_error;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic nrzi;
      logic din;
      logic v;
      logic b;
      logic s;
      logic e;
   } vec_t;

   vec_t tbl[$];

   bit_unstuffer #(.STUFF_LEN(6)) dut (
      .clock           (clock),
      .reset_n         (reset_n),
      .in_bit          (in_bit),
      .nrzi_sending    (nrzi_sending),
      .out_bit         (out_bit),
      .out_valid       (out_valid),
      .unstuff_sending (unstuff_sending),
      .stuff_error     (stuff_error)
   );

   always #5 clock = ~clock;

   function automatic void add(input logic nrzi, input logic din, input logic v,
                               input logic b, input logic s, input logic e);
      vec_t r;
      r.nrzi = nrzi; r.din = din; r.v = v; r.b = b; r.s = s; r.e = e;
      tbl.push_back(r);
   endfunction

   task automatic check(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%b required=%b", name, act, exp);
      end
   endtask

   // Drive one cycle of input and step to just after the next rising edge.
   task automatic step(input logic nrzi, input logic din);
      nrzi_sending = nrzi;
      in_bit       = din;
      @(posedge clock);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_out_bit"},   out_bit,         1'b0);
      check({tag, "_valid"},     out_valid,       1'b0);
      check({tag, "_sending"},   unstuff_sending, 1'b0);
      check({tag, "_error"},     stuff_error,     1'b0);
   endtask

   initial begin
      // Idle, then packet 1111110 (stuffed 0 dropped), then end.
      add(0,1, 0,0,0,0);
      for (int i = 0; i < 6; i++) add(1,1, 1,1,1,0);
      add(1,0, 0,0,1,0);
      add(0,0, 0,0,0,0);
      // Plain data 0,1,0,1,1,0.
      add(1,0, 1,0,1,0);
      add(1,1, 1,1,1,0);
      add(1,0, 1,0,1,0);
      add(1,1, 1,1,1,0);
      add(1,1, 1,1,1,0);
      add(1,0, 1,0,1,0);
      add(0,0, 0,0,0,0);
      add(0,0, 0,0,0,0);
      // 1x6, stuffed 0, 1, 0 -> delivered 1x7, 0.
      for (int i = 0; i < 6; i++) add(1,1, 1,1,1,0);
      add(1,0, 0,0,1,0);
      add(1,1, 1,1,1,0);
      add(1,0, 1,0,1,0);
      add(0,0, 0,0,0,0);
      // 1x7 then 0,0: error on the 7th, sending held until packet end.
      for (int i = 0; i < 6; i++) add(1,1, 1,1,1,0);
      add(1,1, 0,0,1,1);
      add(1,0, 0,0,1,0);
      add(1,0, 0,0,1,0);
      add(0,0, 0,0,0,0);
      add(0,0, 0,0,0,0);
      // 1x6, single-cycle gap, new packet 0,1.
      for (int i = 0; i < 6; i++) add(1,1, 1,1,1,0);
      add(0,0, 0,0,0,0);
      add(1,0, 1,0,1,0);
      add(1,1, 1,1,1,0);
      add(0,0, 0,0,0,0);
      // 1x6, single-cycle gap, new packet 1,1: a carried count would error.
      for (int i = 0; i < 6; i++) add(1,1, 1,1,1,0);
      add(0,1, 0,0,0,0);
      add(1,1, 1,1,1,0);
      add(1,1, 1,1,1,0);
      add(0,0, 0,0,0,0);
      // 1x6, 0, 1x6, 0: both zeros dropped, 12 ones delivered.
      for (int i = 0; i < 6; i++) add(1,1, 1,1,1,0);
      add(1,0, 0,0,1,0);
      for (int i = 0; i < 6; i++) add(1,1, 1,1,1,0);
      add(1,0, 0,0,1,0);
      add(0,0, 0,0,0,0);

      // Reset state.
      reset_n      = 1'b0;
      nrzi_sending = 1'b0;
      in_bit       = 1'b0;
      step(0, 0);
      step(1, 1);
      check_all_zero("reset");
      #2 reset_n = 1'b1;
      step(0, 0);

      // Reset mid-packet with four ones counted.
      for (int i = 0; i < 4; i++) step(1, 1);
      check("pre_reset_valid", out_valid, 1'b1);
      check("pre_reset_sending", unstuff_sending, 1'b1);
      #2 reset_n = 1'b0;
      #1;
      check_all_zero("midrst");
      nrzi_sending = 1'b0;
      #1 reset_n = 1'b1;

      // Table vectors.
      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].nrzi, tbl[i].din);
         check($sformatf("vec%0d_valid", i),   out_valid,       tbl[i].v);
         check($sformatf("vec%0d_sending", i), unstuff_sending, tbl[i].s);
         check($sformatf("vec%0d_error", i),   stuff_error,     tbl[i].e);
         if (tbl[i].v) check($sformatf("vec%0d_bit", i), out_bit, tbl[i].b);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_bit_unstuffer
